pc_fetch_ctrl: RTL
==================

PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port stall_if  input  1  hazard-unit request to freeze fetch.
REQ-005 SHALL have ports id_jal (input, 1) and id_jal_target (input, 32): jal resolved in ID.
REQ-006 SHALL have ports ex_jalr (input, 1) and ex_jalr_target (input, 32): jalr resolved in EX.
REQ-007 SHALL have ports ex_br (input, 1) and ex_br_target (input, 32): taken branch resolved in EX.
REQ-008 SHALL have port pc_if  output  32  current fetch address.
REQ-009 SHALL have port pc_plus4  output  32  pc_if + 4, modulo 2^32.
REQ-010 SHALL have port fetch_valid  output  1  pc_if is a real fetch, not a reset bubble.
REQ-011 SHALL have ports flush_ifid and flush_idex  output  1 each  one-cycle pipeline-register flush pulses.
REQ-012 SHALL have port redirect_cnt  output  32  count of accepted redirects.

Function
REQ-013 SHALL implement states BOOT, RUN and HOLD.
REQ-014 BOOT SHALL last exactly one cycle after reset release, with fetch_valid=0 and pc_if=RESET_PC, and then go to RUN with the PC unchanged.
REQ-015 Redirect priority SHALL be ex_br > ex_jalr > id_jal > sequential, because the EX instruction is the older one.
REQ-016 All targets SHALL have bits [1:0] forced to 0 before use.
REQ-017 RUN with stall_if=0 SHALL load the PC at the next edge with the highest-priority target, or with pc_plus4 when no redirect is present.
REQ-018 RUN with stall_if=1 and no redirect SHALL hold the PC and stay in RUN.
REQ-019 RUN with stall_if=1 and a redirect present SHALL:
- hold the PC;
- latch the winning target and its source (EX or ID) into a pending register;
- go to HOLD.
REQ-020 In HOLD, an asserted ex_br or ex_jalr SHALL overwrite the pending entry; id_jal SHALL be ignored.
REQ-021 In HOLD with stall_if=0, the PC SHALL load the pending target and the state SHALL return to RUN; live redirect inputs in that cycle SHALL be ignored.
REQ-022 A redirect is accepted in the cycle the PC is loaded from a target. In that cycle:
- flush_ifid SHALL be 1 for any source;
- flush_idex SHALL be 1 only for an EX source.
REQ-023 Flush outputs SHALL be combinational from state, stall_if and the redirect inputs, and SHALL be 0 in every other cycle.
REQ-024 redirect_cnt SHALL increment by 1 per accepted redirect and saturate at 32'hFFFF_FFFF.
REQ-025 The sequential PC SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without any flag.
REQ-026 fetch_valid SHALL be 1 in RUN and in HOLD.

Reset
REQ-027 Asserting rst at any time, including mid-HOLD, SHALL immediately set:
- pc_if=RESET_PC, state=BOOT, fetch_valid=0;
- pending register cleared and redirect_cnt=0;
- flush_ifid=0 and flush_idex=0.
REQ-028 No redirect SHALL be accepted while rst=1 or in BOOT.

Structure
REQ-029 Shared package pc_ctrl_pkg SHALL hold the state enum (BOOT/RUN/HOLD), the redirect-source enum (NONE/ID/EX) and the default RESET_PC constant.
REQ-030 The combinational priority select (REQ-015, REQ-016) SHALL be a sub-module pc_target_sel, outputs {valid, source, target}, instantiated once.

Verification
REQ-031 Reset with RESET_PC=32'h100, no stall, no redirect -> pc_if 0x100 (fetch_valid=0), 0x100, 0x104, 0x108.
REQ-032 RUN at pc 0x200, ex_br=1 (0x40) and id_jal=1 (0x80) in the same cycle -> next pc 0x40, flush_ifid=1, flush_idex=1, redirect_cnt +1.
REQ-033 stall_if=1 with id_jal=1 (0x300) for 3 cycles -> pc held, state HOLD; stall released -> pc 0x300, flush_ifid=1, flush_idex=0.
REQ-034 In HOLD with pending ID 0x300, ex_jalr=1 (0x503) -> on release pc 0x500 and both flushes=1.
REQ-035 pc 32'hFFFF_FFFC with no redirect -> next pc 0x0; redirect_cnt preset to 32'hFFFF_FFFF plus one redirect -> stays 32'hFFFF_FFFF.
REQ-036 rst asserted mid-HOLD between edges -> pc_if=RESET_PC immediately; after release BOOT, then RUN with the pending target discarded.

Source files
------------

// File: rtl/pc_ctrl_pkg.sv
// Shared definitions for the instruction-fetch PC controller.
//   fetch_state_t : controller states (BOOT / RUN / HOLD)
//   redir_src_t   : origin of a redirect (NONE / ID / EX)
//   DEFAULT_RESET_PC : default fetch address after reset
//   align4()      : clears the two low address bits of a target
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_t;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ID   = 2'd1,
        EX   = 2'd2
    } redir_src_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Masking (instead of slicing) keeps every target bit in use.
    function automatic logic [31:0] align4(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/pc_target_sel.sv
// Combinational redirect priority select.
// Priority: ex_br > ex_jalr > id_jal. The EX-stage instruction is older,
// so its redirect always wins over a jal resolved in ID.
// Ports:
//   i_id_en          : when 0 the ID-stage jal is not considered
//   i_ex_br/_target  : taken branch from EX
//   i_ex_jalr/_target: jalr from EX
//   i_id_jal/_target : jal from ID
//   o_valid          : some redirect is present
//   o_source         : source of the winning redirect
//   o_target         : winning target, word-aligned
module pc_target_sel
    import pc_ctrl_pkg::*;
(
    input  logic        i_id_en,
    input  logic        i_ex_br,
    input  logic [31:0] i_ex_br_target,
    input  logic        i_ex_jalr,
    input  logic [31:0] i_ex_jalr_target,
    input  logic        i_id_jal,
    input  logic [31:0] i_id_jal_target,
    output logic        o_valid,
    output redir_src_t  o_source,
    output logic [31:0] o_target
);

    always_comb begin
        o_valid  = 1'b0;
        o_source = NONE;
        o_target = 32'h0000_0000;
        if (i_ex_br) begin
            o_valid  = 1'b1;
            o_source = EX;
            o_target = align4(i_ex_br_target);
        end else if (i_ex_jalr) begin
            o_valid  = 1'b1;
            o_source = EX;
            o_target = align4(i_ex_jalr_target);
        end else if (i_id_jal && i_id_en) begin
            o_valid  = 1'b1;
            o_source = ID;
            o_target = align4(i_id_jal_target);
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller.
// Holds the fetch PC, selects between sequential and redirect targets,
// parks a redirect that arrives while fetch is stalled (HOLD), and issues
// one-cycle flush pulses for the IF/ID and ID/EX pipeline registers.
// Ports:
//   clk, rst          : clock; asynchronous active-high reset
//   stall_if          : freeze fetch request from the hazard unit
//   id_jal(_target)   : jal resolved in ID
//   ex_jalr(_target)  : jalr resolved in EX
//   ex_br(_target)    : taken branch resolved in EX
//   pc_if, pc_plus4   : current fetch address and its +4
//   fetch_valid       : pc_if is a real fetch (0 in the post-reset bubble)
//   flush_ifid/idex   : flush pulses, asserted in the cycle a redirect is taken
//   redirect_cnt      : saturating count of accepted redirects
module pc_fetch_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_if,
    input  logic        id_jal,
    input  logic [31:0] id_jal_target,
    input  logic        ex_jalr,
    input  logic [31:0] ex_jalr_target,
    input  logic        ex_br,
    input  logic [31:0] ex_br_target,
    output logic [31:0] pc_if,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        flush_ifid,
    output logic        flush_idex,
    output logic [31:0] redirect_cnt
);

    fetch_state_t r_state, w_state_next;
    logic [31:0]  r_pc, w_pc_next;
    logic [31:0]  r_pend_target, w_pend_target_next;
    redir_src_t   r_pend_src, w_pend_src_next;
    logic [31:0]  r_redirect_cnt;

    logic         w_sel_valid;
    redir_src_t   w_sel_source;
    logic [31:0]  w_sel_target;
    logic         w_accept;
    redir_src_t   w_accept_src;

    // A pending ID redirect can only be displaced by an older (EX) one,
    // so the jal input is masked out while holding.
    pc_target_sel u_target_sel (
        .i_id_en          (r_state != HOLD),
        .i_ex_br          (ex_br),
        .i_ex_br_target   (ex_br_target),
        .i_ex_jalr        (ex_jalr),
        .i_ex_jalr_target (ex_jalr_target),
        .i_id_jal         (id_jal),
        .i_id_jal_target  (id_jal_target),
        .o_valid          (w_sel_valid),
        .o_source         (w_sel_source),
        .o_target         (w_sel_target)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= BOOT;
            r_pc          <= RESET_PC;
            r_pend_target <= 32'h0000_0000;
            r_pend_src    <= NONE;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_pend_target <= w_pend_target_next;
            r_pend_src    <= w_pend_src_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_redirect_cnt <= 32'h0000_0000;
        end else if (w_accept && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_pend_target_next = r_pend_target;
        w_pend_src_next    = r_pend_src;
        w_accept           = 1'b0;
        w_accept_src       = NONE;
        unique case (r_state)
            BOOT: begin
                // One bubble cycle; PC stays at the reset address.
                w_state_next = RUN;
            end
            RUN: begin
                if (!stall_if) begin
                    if (w_sel_valid) begin
                        w_pc_next    = w_sel_target;
                        w_accept     = 1'b1;
                        w_accept_src = w_sel_source;
                    end else begin
                        w_pc_next = r_pc + 32'd4;
                    end
                end else if (w_sel_valid) begin
                    w_pend_target_next = w_sel_target;
                    w_pend_src_next    = w_sel_source;
                    w_state_next       = HOLD;
                end
            end
            HOLD: begin
                if (!stall_if) begin
                    // Live redirects are ignored on the release cycle.
                    w_pc_next          = r_pend_target;
                    w_accept           = 1'b1;
                    w_accept_src       = r_pend_src;
                    w_pend_target_next = 32'h0000_0000;
                    w_pend_src_next    = NONE;
                    w_state_next       = RUN;
                end else if (w_sel_valid) begin
                    w_pend_target_next = w_sel_target;
                    w_pend_src_next    = w_sel_source;
                end
            end
            default: begin
                w_state_next = BOOT;
                w_pc_next    = RESET_PC;
            end
        endcase
    end

    assign pc_if        = r_pc;
    assign pc_plus4     = r_pc + 32'd4;
    assign fetch_valid  = (r_state == RUN) || (r_state == HOLD);
    assign flush_ifid   = w_accept;
    assign flush_idex   = w_accept && (w_accept_src == EX);
    assign redirect_cnt = r_redirect_cnt;

endmodule
